// File: rtl/fpu_res_wbq_pkg.sv
// Shared FP package: ptype encodings, csrfpu exception bit indices and
// writeback-queue sizing.
package fpu_res_wbq_pkg;

  typedef enum logic [1:0] {
    ptype_zero = 2'd0,
    ptype_norm = 2'd1,
    ptype_inf  = 2'd2,
    ptype_nan  = 2'd3
  } ptype_e;

  localparam int unsigned csrfpu_nx   = 0;
  localparam int unsigned csrfpu_uf   = 1;
  localparam int unsigned csrfpu_of   = 2;
  localparam int unsigned csrfpu_dz   = 3;
  localparam int unsigned csrfpu_nv   = 4;
  localparam int unsigned csrfpu_de   = 5;
  localparam int unsigned csrfpu_snan = 6;
  localparam int unsigned csrfpu_iov  = 7;
  localparam int unsigned csrfpu_pe   = 8;
  localparam int unsigned csrfpu_ue   = 9;
  localparam int unsigned csrfpu_oe   = 10;
  localparam int unsigned CSRFPU_W    = 11;

  localparam int unsigned FPWB_DEPTH = 4;
  localparam int unsigned FPWB_TAGW  = 9;

  function automatic int unsigned fpwb_entry_w(input int unsigned tagw);
    return tagw + 68 + 16 + CSRFPU_W;
  endfunction

  localparam int unsigned FPWB_ENTRY_W = fpwb_entry_w(FPWB_TAGW);

endpackage

// File: rtl/fpu_res_wbq_ram.sv
// Writeback-queue storage: one synchronous write port, one asynchronous read port.
module fpu_res_wbq_ram #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 104,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fpu_res_wbq.sv
// In-order FP result writeback queue with sticky exception flags, trap
// detection and sticky overflow error.
module fpu_res_wbq
  import fpu_res_wbq_pkg::*;
#(
  parameter  int unsigned DEPTH = FPWB_DEPTH,
  parameter  int unsigned TAGW  = FPWB_TAGW,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_en,
  input  logic [TAGW-1:0]     in_tag,
  input  logic [67:0]         in_res,
  input  logic [15:0]         in_res_hi,
  input  logic [CSRFPU_W-1:0] in_raise,
  output logic                wb_vld,
  input  logic                wb_rdy,
  output logic [TAGW-1:0]     wb_tag,
  output logic [67:0]         wb_res,
  output logic [15:0]         wb_res_hi,
  output logic [CSRFPU_W-1:0] wb_raise,
  output logic                wb_trap,
  input  logic [CSRFPU_W-1:0] excpt_mask,
  input  logic                flag_clr,
  output logic [CSRFPU_W-1:0] flags,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = fpwb_entry_w(TAGW);

  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CSRFPU_W-1:0] flags_q, flags_d;
  logic                ovf_q, ovf_d;
  logic                enq, deq;
  logic [EW-1:0]       wdata, rdata;

  assign wdata = {in_tag, in_res, in_res_hi, in_raise};

  fpu_res_wbq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (enq & ~rst),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wb_vld = (count_q != '0);
    full   = (count_q == CW'(DEPTH));
    deq    = wb_vld & wb_rdy;
    // a slot freed by this cycle's dequeue may be refilled even when full
    enq    = in_en & (~full | deq);

    {wb_tag, wb_res, wb_res_hi, wb_raise} = wb_vld ? rdata : '0;
    wb_trap = wb_vld & (|(wb_raise & ~excpt_mask));

    wptr_d = enq ? wptr_q + PW'(1) : wptr_q;
    rptr_d = deq ? rptr_q + PW'(1) : rptr_q;

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    flags_d = (flag_clr ? '0 : flags_q) | (deq ? wb_raise : '0);
    ovf_d   = ovf_q | (in_en & full & ~deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign flags = flags_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fpu_res_wbq.sv
// Self-checking bench for fpu_res_wbq: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_fpu_res_wbq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [8:0]  in_tag;
  logic [67:0] in_res;
  logic [15:0] in_res_hi;
  logic [10:0] in_raise;
  logic        wb_vld, wb_rdy;
  logic [8:0]  wb_tag;
  logic [67:0] wb_res;
  logic [15:0] wb_res_hi;
  logic [10:0] wb_raise;
  logic        wb_trap;
  logic [10:0] excpt_mask;
  logic        flag_clr;
  logic [10:0] flags;
  logic [2:0]  count;
  logic        full, ovf;

  fpu_res_wbq #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_tag(in_tag), .in_res(in_res),
    .in_res_hi(in_res_hi), .in_raise(in_raise), .wb_vld(wb_vld), .wb_rdy(wb_rdy),
    .wb_tag(wb_tag), .wb_res(wb_res), .wb_res_hi(wb_res_hi), .wb_raise(wb_raise),
    .wb_trap(wb_trap), .excpt_mask(excpt_mask), .flag_clr(flag_clr), .flags(flags),
    .count(count), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  tag;
    logic [67:0] res;
    logic [15:0] hi;
    logic [10:0] raise;
  } ent_t;

  ent_t        mq[$];
  logic [10:0] m_flags = '0;
  bit          m_ovf   = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
  endtask

  function automatic logic [67:0] rnd68();
    logic [67:0] r;
    r = {4'($urandom), $urandom, $urandom};
    return r;
  endfunction

  // Drive one cycle's inputs on the falling edge, check outputs against the
  // model before the next rising edge, then advance the model.
  task automatic step(input bit r, input bit en, input logic [8:0] tg, input logic [67:0] rs,
                      input logic [15:0] hi, input logic [10:0] rz, input bit rdy,
                      input logic [10:0] msk, input bit clr);
    ent_t h, e;
    bit   vld, deq, enq, fullp;
    @(negedge clk);
    rst = r; in_en = en; in_tag = tg; in_res = rs; in_res_hi = hi; in_raise = rz;
    wb_rdy = rdy; excpt_mask = msk; flag_clr = clr;
    #1;
    vld = (mq.size() != 0);
    h   = vld ? mq[0] : '0;
    chk("wb_vld", wb_vld, vld);
    chk("wb_tag", wb_tag, h.tag);
    chk("wb_res", wb_res, h.res);
    chk("wb_res_hi", wb_res_hi, h.hi);
    chk("wb_raise", wb_raise, h.raise);
    chk("wb_trap", wb_trap, vld && ((h.raise & ~msk) != '0));
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("flags", flags, m_flags);
    chk("ovf", ovf, m_ovf);
    if (r) begin
      mq.delete();
      m_flags = '0;
      m_ovf   = 1'b0;
    end else begin
      deq   = vld && rdy;
      fullp = (mq.size() == DEPTH);
      enq   = en && (!fullp || deq);
      m_flags = (clr ? 11'h000 : m_flags) | (deq ? h.raise : 11'h000);
      if (en && fullp && !deq) m_ovf = 1'b1;
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.tag = tg; e.res = rs; e.hi = hi; e.raise = rz;
        mq.push_back(e);
      end
    end
  endtask

  task automatic push(input logic [8:0] tg, input logic [10:0] rz, input bit rdy);
    step(1'b0, 1'b1, tg, rnd68(), 16'($urandom), rz, rdy, 11'h7FF, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 9'($urandom), rnd68(), 16'($urandom), 11'($urandom), rdy, 11'h7FF, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_tag = '0; in_res = '0; in_res_hi = '0; in_raise = '0;
    wb_rdy = 1'b0; excpt_mask = 11'h7FF; flag_clr = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 11'h7FF, 1'b0);
    idle(1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_vld", wb_vld, 1'b0);

    // single op, no bypass, then drain
    step(1'b0, 1'b1, 9'h005, 68'h2_3FF0_0000_0000_0000, 16'h3FFF, 11'h000, 1'b1, 11'h7FF, 1'b0);
    chk("single_nobypass", wb_vld, 1'b0);
    idle(1'b1);
    chk("single_tag", wb_tag, 9'h005);
    chk("single_res", wb_res, 68'h2_3FF0_0000_0000_0000);
    idle(1'b1);
    chk("single_empty", count, 3'd0);

    // fill, overflow, in-order drain
    for (int i = 0; i < 4; i++) push(9'(i), 11'h000, 1'b0);
    push(9'h1FF, 11'h000, 1'b0);
    chk("fill_count", count, 3'd4);
    chk("fill_full", full, 1'b1);
    idle(1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_count", count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain_order", wb_tag, 9'(i));
    end

    // full with simultaneous enq+deq
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 11'h7FF, 1'b0);
    for (int i = 0; i < 4; i++) push(9'(16 + i), 11'h000, 1'b0);
    push(9'h1AA, 11'h000, 1'b1);
    idle(1'b0);
    chk("enqdeq_count", count, 3'd4);
    chk("enqdeq_ovf", ovf, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // sticky flags with clear racing a dequeue
    push(9'h010, 11'h001, 1'b0);
    push(9'h011, 11'h010, 1'b0);
    push(9'h012, 11'h100, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 11'h7FF, 1'b1);
    chk("flags_acc", flags, 11'h011);
    idle(1'b0);
    chk("flags_clr", flags, 11'h100);

    // trap masking, dequeue not blocked
    push(9'h020, 11'h004, 1'b0);
    push(9'h021, 11'h004, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 11'h7FB, 1'b0);
    chk("trap_unmasked", wb_trap, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 11'h7FF, 1'b0);
    chk("trap_masked", wb_trap, 1'b0);
    idle(1'b0);
    chk("trap_drained", count, 3'd0);

    // reset mid-run with in_en/wb_rdy/flag_clr asserted
    for (int i = 0; i < 3; i++) push(9'(32 + i), 11'h002, 1'b0);
    step(1'b1, 1'b1, 9'h0EE, rnd68(), 16'h0, 11'h7FF, 1'b1, 11'h000, 1'b1);
    push(9'h0C3, 11'h000, 1'b0);
    chk("rst_mid_count", count, 3'd0);
    idle(1'b0);
    chk("rst_mid_tag", wb_tag, 9'h0C3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), 9'($urandom), rnd68(),
           16'($urandom), 11'($urandom), ($urandom_range(0, 99) < 60), 11'($urandom),
           ($urandom_range(0, 99) < 10));
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpu_res_wbq.md
# fpu_res_wbq

In-order result/writeback queue that sits directly downstream of the FP multiply stage. It captures each valid 68-bit result, its 16-bit high part and its 11-bit exception-raise vector into a small FIFO. Entries drain to the FP writeback port under a valid/ready handshake. On every accepted writeback the block ORs the entry's raise bits into sticky status flags and flags unmasked exceptions as traps.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2
- TAGW, 9, destination-register tag width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_en  in  1  result valid from the multiply stage this cycle
- in_tag  in  TAGW  destination tag for the result
- in_res  in  68  result {ptype[67:66], payload[65:0]}
- in_res_hi  in  16  sign/exponent high part (extended format)
- in_raise  in  11  exception raise vector, csrfpu_* bit positions
- wb_vld  out  1  head entry valid
- wb_rdy  in  1  writeback port accepts head
- wb_tag  out  TAGW  head tag
- wb_res  out  68  head result
- wb_res_hi  out  16  head high part
- wb_raise  out  11  head raise vector
- wb_trap  out  1  |(wb_raise & ~excpt_mask), qualified by wb_vld
- excpt_mask  in  11  1 = exception masked (no trap)
- flag_clr  in  1  clear sticky flags
- flags  out  11  sticky accumulated raise bits
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count==DEPTH
- ovf  out  1  sticky overflow error

## Operation
- Enqueue: `enq = in_en & (~full | deq)`. On enq, write {in_tag,in_res,in_res_hi,in_raise} at wptr. Advance wptr modulo DEPTH.
- Dequeue: `deq = wb_vld & wb_rdy`. Advance rptr modulo DEPTH.
- Count: count += enq - deq. Simultaneous enq and deq leaves count unchanged. This is legal when full and when count==1.
- Overflow: in_en & full & ~deq sets ovf. The input is dropped and queue contents are unchanged. ovf clears only on rst. The issuing logic must not rely on dropping.
- The data at in_* is ignored when in_en=0, and may be high-Z/X.
- Head outputs are driven from storage at rptr. wb_vld = (count!=0). When wb_vld=0, the wb_* data outputs are 0.
- Flags: next = (flag_clr ? 0 : flags) | (deq ? wb_raise : 0). A raise bit dequeued in the same cycle as flag_clr survives.
- wb_trap is combinational from the head and excpt_mask. It is reported regardless of wb_rdy. The trap does not block dequeue.
- Results pass through bit-exact. There is no reformatting of ptype or payload.

## Timing
- Reset values: count=0, full=0, wb_vld=0, wb_tag/wb_res/wb_res_hi/wb_raise=0, wb_trap=0, flags=0, ovf=0, wptr=rptr=0. Storage contents are don't-care.
- Latency: an enqueue at edge N into an empty queue gives wb_vld=1 with that entry after edge N. There is no same-cycle bypass.
- Throughput: 1 enq + 1 deq per cycle sustained.
- Pointer wrap from DEPTH-1 to 0 is seamless; full and empty are distinguished by count.
- rst while the queue is non-empty discards all entries and returns to the reset values on the next edge. in_en, wb_rdy and flag_clr are ignored during rst.
- The producer updates on the falling edge, so in_* is stable half a cycle before the capturing rising edge.
- flags and ovf update one edge after the causing handshake.

## Structure
- Existing shared package/include: ptype_* encodings and csrfpu_* bit indices. This block reuses them and defines no new copies.
- Add to the shared package: FPWB_DEPTH and FPWB_ENTRY_W = TAGW+68+16+11.
- Sub-module fpu_res_wbq_ram: DEPTH x FPWB_ENTRY_W storage with 1 synchronous write and 1 asynchronous read port.
- The top level holds the pointers, count, flags, ovf and trap logic.

## Test plan
- Single op: in_en=1, tag=0x05, res=68'h2_3FF0_0000_0000_0000, raise=0, with wb_rdy=1. Expect wb_vld=1 next cycle with identical data, count 1→0, flags=0.
- Fill/backpressure: wb_rdy=0 with 4 enqueues. Expect count=4 and full=1. A 5th in_en sets ovf=1 with count still 4. Then wb_rdy=1 drains tags in order 0,1,2,3.
- Full with simultaneous enq+deq: count=4, in_en=1, wb_rdy=1. Expect count stays 4, ovf=0, and the new tag appears 4 dequeues later.
- Flags: dequeue entries with raise=11'h001 then 11'h010. Expect flags=11'h011. flag_clr together with a dequeue of raise=11'h100 gives flags=11'h100.
- Trap: head raise=11'h004. excpt_mask=11'h7FB gives wb_trap=1; excpt_mask=11'h7FF gives wb_trap=0. The dequeue proceeds in both cases.
- Reset mid-run: count=3, assert rst for 1 cycle. Expect all outputs at reset values next cycle. A following enqueue appears with tag intact after 1 cycle.
